// File: rtl/right_shift_seq.sv
// Multi-cycle logical/arithmetic right shifter: retires up to STEP bit positions
// per clock under a start/busy/done handshake; out holds the last completed result.
module right_shift_seq #(
    parameter int WIDTH = 64,
    parameter int STEP  = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     arith,
    input  logic [$clog2(WIDTH)-1:0] SHAMT,
    input  logic [WIDTH-1:0]         in,
    output logic [WIDTH-1:0]         out,
    output logic                     busy,
    output logic                     done
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [SW-1:0] STEP_AMT = SW'(STEP);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_data;
    logic [SW-1:0]    r_rem;
    logic             r_fill;
    logic [WIDTH-1:0] r_out;

    logic [SW-1:0]    w_k;
    logic [SW-1:0]    w_rem_next;
    logic [WIDTH-1:0] w_shifted;

    // Shift right by k, forcing the vacated top k bits to the fill value.
    function automatic logic [WIDTH-1:0] shift_fill(input logic [WIDTH-1:0] d,
                                                    input logic [SW-1:0]    k,
                                                    input logic             f);
        logic [WIDTH-1:0] mask;
        mask = ~({WIDTH{1'b1}} >> k);
        return (d >> k) | (f ? mask : '0);
    endfunction

    always_comb begin
        w_k        = (r_rem < STEP_AMT) ? r_rem : STEP_AMT;
        w_rem_next = r_rem - w_k;
        w_shifted  = shift_fill(r_data, w_k, r_fill);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_rem   <= '0;
            r_fill  <= 1'b0;
            r_out   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_data <= in;
                        r_rem  <= SHAMT;
                        r_fill <= arith & in[WIDTH-1];
                        // A zero shift completes immediately with the operand itself.
                        if (SHAMT == '0) begin
                            r_state <= S_DONE;
                            r_out   <= in;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_data <= w_shifted;
                    r_rem  <= w_rem_next;
                    if (w_rem_next == '0) begin
                        r_state <= S_DONE;
                        r_out   <= w_shifted;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out  = r_out;
    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);
endmodule

// File: doc/right_shift_seq.md
# right_shift_seq

Multi-cycle right shifter for the datapath: shifts a 64-bit operand right by 0–63 bits, logically (LSR) or arithmetically (ASR), retiring up to 3 bit positions per clock. It is the right-direction counterpart to the single-cycle 0–3 left shift stage. The ALU/execute control launches it with a start/busy/done handshake when an LSR/ASR instruction needs a full 6-bit shift amount.

## Interface
Parameters:
- WIDTH, 64, operand width; shift amount width is $clog2(WIDTH) = 6.
- STEP, 3, maximum bit positions retired per SHIFT cycle.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- arith  input  1  1 = ASR (sign fill), 0 = LSR (zero fill); captured with start.
- SHAMT  input  6  shift amount 0–63; captured with start.
- in  input  64  operand; captured with start.
- out  output  64  result register.
- busy  output  1  high while a request is in progress (SHIFT state).
- done  output  1  one-cycle pulse: out holds the final result.

## Operation
- Internal registers: data[63:0], rem[5:0], fill (1 bit), state ∈ {IDLE, SHIFT, DONE}.
- IDLE: busy=0, done=0. On a start=1 edge: data←in, rem←SHAMT, fill←arith & in[63]. Next state SHIFT if SHAMT≠0, else DONE.
- SHIFT: busy=1. Each edge: k = min(rem, STEP); data ← data shifted right by k, vacated top k bits = fill; rem ← rem−k. When rem−k = 0, next state is DONE; otherwise stay in SHIFT.
- DONE: done=1, busy=0, out = final data. On the next edge: if start=1, accept a new request exactly as in IDLE (back-to-back). Otherwise go to IDLE.
- out is updated only on the edge entering DONE. It holds that value through IDLE until the next request completes.
- start while in SHIFT is ignored. in/SHAMT/arith changes after capture have no effect.
- fill is computed from the captured in[63]. ASR by 63 gives all sign bits; LSR by 63 gives in[63] in bit 0.
- There are no overflow or flag outputs. Results are exactly (in >> SHAMT) or (in >>> SHAMT).

## Timing
- Reset (synchronous, dominant over start): state=IDLE, out=0, busy=0, done=0, data=0, rem=0, fill=0. This also applies mid-SHIFT or in DONE: the request is discarded, no done pulse is issued, and out is cleared.
- Let start be sampled at edge N and c = ceil(SHAMT/3):
  - SHAMT=0: done=1 in the cycle after edge N.
  - SHAMT>0: busy=1 in the cycles after edges N … N+c−1; done=1 in the cycle after edge N+c.
- Worst case is SHAMT=63: c=21, so done follows the 21st edge after start.
- done is exactly one cycle wide unless a back-to-back request with SHAMT=0 is accepted in DONE. In that case done stays high for one more cycle with the new result.
- busy and done are never high together.
- Minimum request-to-request spacing is c+1 edges.

## Test plan
- LSR, in=64'hFFFF_FFFF_FFFF_FFFF, SHAMT=4, arith=0 → busy for 2 cycles, then done=1 with out=64'h0FFF_FFFF_FFFF_FFFF.
- ASR, in=64'h8000_0000_0000_0000, SHAMT=63, arith=1 → done after edge N+21, out=64'hFFFF_FFFF_FFFF_FFFF. Same stimulus with arith=0 → out=64'h1.
- SHAMT=0, in=64'h1 → no busy cycle; done in the cycle after the start edge; out=64'h1.
- Launch LSR of 64'hF0 by 6. Pulse start with new in/SHAMT during SHIFT → ignored; out=64'h3 after c=2.
- Launch ASR of 64'h8000_0000_0000_0000 by 30. Assert reset at SHIFT cycle 4 → next cycle busy=0, done=0, out=0, and no done pulse follows. A fresh start then completes normally.
- Back-to-back: hold start=1 in DONE with in=64'h100, SHAMT=8, arith=0 → accepted without an IDLE cycle; done after c=3 more edges with out=64'h1.
